// File: rtl/if_fetch_controller_pkg.sv
// Shared types and default constants for the instruction fetch controller.
// Optional feature macro used by the top level: IF_FETCH_PERF_EN.
package if_fetch_controller_pkg;

    // Fetch FSM: normal fetch, loader owns the memory port, or halted out of range.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LDR   = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    typedef logic [31:0] word_t;

    localparam int unsigned DEFAULT_MEM_DEPTH = 1024;
    localparam int unsigned DEFAULT_RESET_PC  = 0;

endpackage

// File: rtl/if_fetch_ldr_arb.sv
// Loader arbitration: decides when the loader/debug port owns instruction memory
// and limits consecutive grants so fetch is never starved for long.
module if_fetch_ldr_arb #(
    parameter int unsigned LDR_MAX_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ldr_req,
    input  logic stall,
    input  logic redirect,
    output logic ldr_grant
);

    localparam int unsigned CW = $clog2(LDR_MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(LDR_MAX_BURST);

    logic [CW-1:0] burst_cnt;

    // A stalled pipeline loses nothing, so the burst limit only applies when fetch could run.
    always_comb begin
        ldr_grant = 1'b0;
        if (!reset && ldr_req && !redirect && (stall || (burst_cnt < MAX_CNT)))
            ldr_grant = 1'b1;
    end

    // Count consecutive grants; saturate so long stalled bursts cannot wrap, clear on any gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            burst_cnt <= '0;
        else if (ldr_grant) begin
            if (burst_cnt != MAX_CNT)
                burst_cnt <= burst_cnt + 1'b1;
        end
        else
            burst_cnt <= '0;
    end

endmodule

// File: rtl/if_fetch_controller.sv
// Instruction fetch controller: drives the instruction memory address, registers
// fetched instructions, handles redirect/stall, shares the port with a loader and
// halts when the pc leaves the memory range.
// Define IF_FETCH_PERF_EN to add saturating fetch/bubble performance counters.
module if_fetch_controller
    import if_fetch_controller_pkg::*;
#(
    parameter int unsigned RESET_PC      = DEFAULT_RESET_PC,
    parameter int unsigned MEM_DEPTH     = DEFAULT_MEM_DEPTH,
    parameter int unsigned LDR_MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        ldr_req,
    input  logic [9:0]  ldr_addr,
    output logic        ldr_grant,
    output logic [31:0] ldr_data,
    output logic        halted
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_bubble
`endif
);

    localparam word_t DEPTH_W = word_t'(MEM_DEPTH);
    localparam word_t RESET_W = word_t'(RESET_PC);

    fetch_state_t state;
    word_t        pc;

    if_fetch_ldr_arb #(
        .LDR_MAX_BURST(LDR_MAX_BURST)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .ldr_req  (ldr_req),
        .stall    (stall),
        .redirect (redirect),
        .ldr_grant(ldr_grant)
    );

    // The loader address replaces the pc on the memory port only while it is granted.
    always_comb begin
        mem_addr = pc;
        if (ldr_grant)
            mem_addr = {22'd0, ldr_addr};
    end

    assign ldr_data = mem_data;

    // Fetch FSM and pc datapath; redirect beats stall, stall beats loader bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_W;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end
        else if (redirect) begin
            state       <= FETCH;
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end
        else if (stall) begin
            if (state != HALT)
                state <= ldr_grant ? LDR : FETCH;
        end
        else if (ldr_grant) begin
            instr_valid <= 1'b0;
            if (state != HALT)
                state <= LDR;
        end
        else if (state == HALT) begin
            instr_valid <= 1'b0;
        end
        else if (pc >= DEPTH_W) begin
            state       <= HALT;
            halted      <= 1'b1;
            instr_valid <= 1'b0;
        end
        else begin
            state       <= FETCH;
            instr       <= mem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd1;
        end
    end

`ifdef IF_FETCH_PERF_EN
    // Every post-reset cycle is either a delivered instruction or a bubble; both saturate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch  <= '0;
            perf_bubble <= '0;
        end
        else if (instr_valid) begin
            if (perf_fetch != 32'hFFFF_FFFF)
                perf_fetch <= perf_fetch + 32'd1;
        end
        else begin
            if (perf_bubble != 32'hFFFF_FFFF)
                perf_bubble <= perf_bubble + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_controller.sv
// Self-checking bench for if_fetch_controller with a behavioural reference model.
// Perf-counter scenario is compiled in when IF_FETCH_PERF_EN is defined.
module tb_if_fetch_controller;

    localparam int LDR_MAX = 4;
    localparam int DEPTH   = 1024;
    localparam int RST_PC  = 0;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        ldr_req;
    logic [9:0]  ldr_addr;
    logic        ldr_grant;
    logic [31:0] ldr_data;
    logic        halted;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_bubble;
`endif

    logic [31:0] salt;

    int checks;
    int errors;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_valid;
    logic        m_halted;
    int          m_burst;

    // Per-cycle observations
    logic        g;
    logic        eg;
    logic [31:0] a;
    logic [31:0] ea;
    logic [31:0] d;

    if_fetch_controller #(
        .RESET_PC     (RST_PC),
        .MEM_DEPTH    (DEPTH),
        .LDR_MAX_BURST(LDR_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .ldr_req    (ldr_req),
        .ldr_addr   (ldr_addr),
        .ldr_grant  (ldr_grant),
        .ldr_data   (ldr_data),
        .halted     (halted)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_bubble(perf_bubble)
`endif
    );

    // Instruction memory: word k holds k XOR salt.
    assign mem_data = mem_addr ^ salt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_reset();
        m_pc     = 32'(RST_PC);
        m_instr  = '0;
        m_ipc    = '0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_burst  = 0;
    endtask

    // Drive one cycle of inputs, sample the combinational outputs mid-cycle, advance
    // the reference model and return #1 after the rising edge.
    task automatic drive_cycle(input logic s, input logic r, input logic [31:0] rpc,
                               input logic lr, input logic [9:0] la);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        ldr_req     = lr;
        ldr_addr    = la;
        #2;
        g  = ldr_grant;
        a  = mem_addr;
        d  = ldr_data;
        eg = lr && !r && (s || (m_burst < LDR_MAX));
        ea = eg ? {22'd0, la} : m_pc;
        if (r) begin
            m_pc     = rpc;
            m_valid  = 1'b0;
            m_halted = 1'b0;
        end
        else if (s) begin
        end
        else if (eg || m_halted) begin
            m_valid = 1'b0;
        end
        else if (m_pc >= 32'(DEPTH)) begin
            m_halted = 1'b1;
            m_valid  = 1'b0;
        end
        else begin
            m_instr = m_pc ^ salt;
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 1;
        end
        m_burst = eg ? m_burst + 1 : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        ldr_req = 1'b1; ldr_addr = 10'h155; salt = '0;
        #3;
        checks++; if (ldr_grant !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant: got %0b expected 0", ldr_grant); end
        checks++; if (instr !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr: got %0h expected 0", instr); end
        checks++; if (instr_pc !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr_pc: got %0h expected 0", instr_pc); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", instr_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %0b expected 0", halted); end
        checks++; if (mem_addr !== 32'(RST_PC)) begin errors++; $display("[TB] FAIL reset_mem_addr: got %0h expected %0h", mem_addr, RST_PC); end
        @(posedge clk);
        #1;
        reset = 1'b0; ldr_req = 1'b0;
        model_reset();
    endtask

    task automatic test_free_run();
        for (int k = 0; k < 8; k++) begin
            drive_cycle(1'b0, 1'b0, 32'd0, 1'b0, 10'd0);
            checks++; if (a !== 32'(k)) begin errors++; $display("[TB] FAIL free_addr: got %0h expected %0h", a, k); end
            checks++; if (instr_pc !== 32'(k)) begin errors++; $display("[TB] FAIL free_instr_pc: got %0h expected %0h", instr_pc, k); end
            checks++; if (instr !== 32'(k)) begin errors++; $display("[TB] FAIL free_instr: got %0h expected %0h", instr, k); end
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL free_valid: got %0b expected 1", instr_valid); end
        end
    endtask

    task automatic test_redirect_stall();
        drive_cycle(1'b1, 1'b1, 32'h20, 1'b1, 10'h3);
        checks++; if (g !== 1'b0) begin errors++; $display("[TB] FAIL redir_grant: got %0b expected 0", g); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush: got %0b expected 0", instr_valid); end
        drive_cycle(1'b0, 1'b0, 32'd0, 1'b0, 10'd0);
        checks++; if (instr_pc !== 32'h20) begin errors++; $display("[TB] FAIL redir_target: got %0h expected 20", instr_pc); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL redir_valid: got %0b expected 1", instr_valid); end
        checks++; if (instr !== (32'h20 ^ salt)) begin errors++; $display("[TB] FAIL redir_instr: got %0h expected %0h", instr, 32'h20 ^ salt); end
    endtask

    task automatic test_ldr_burst();
        logic [9:0] pattern;
        int         fetched;
        logic [9:0] la;
        pattern = '0;
        fetched = 0;
        for (int k = 0; k < 10; k++) begin
            la = 10'($urandom);
            drive_cycle(1'b0, 1'b0, 32'd0, 1'b1, la);
            pattern = {pattern[8:0], g};
            if (instr_valid === 1'b1) fetched++;
            checks++; if (a !== ea) begin errors++; $display("[TB] FAIL burst_addr: got %0h expected %0h", a, ea); end
            if (eg) begin
                checks++; if (d !== ({22'd0, la} ^ salt)) begin errors++; $display("[TB] FAIL burst_ldr_data: got %0h expected %0h", d, {22'd0, la} ^ salt); end
            end
        end
        checks++; if (pattern !== 10'b1111011110) begin errors++; $display("[TB] FAIL burst_pattern: got %b expected 1111011110", pattern); end
        checks++; if (fetched != 2) begin errors++; $display("[TB] FAIL burst_fetches: got %0d expected 2", fetched); end
        ldr_req = 1'b0;
    endtask

    task automatic test_halt();
        drive_cycle(1'b0, 1'b1, 32'd1022, 1'b0, 10'd0);
        drive_cycle(1'b0, 1'b0, 32'd0, 1'b0, 10'd0);
        checks++; if (instr_pc !== 32'd1022 || instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL halt_fetch1022: got pc %0d valid %0b expected 1022 1", instr_pc, instr_valid); end
        drive_cycle(1'b0, 1'b0, 32'd0, 1'b0, 10'd0);
        checks++; if (instr_pc !== 32'd1023 || instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL halt_fetch1023: got pc %0d valid %0b expected 1023 1", instr_pc, instr_valid); end
        drive_cycle(1'b0, 1'b0, 32'd0, 1'b0, 10'd0);
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_enter: got halted %0b valid %0b expected 1 0", halted, instr_valid); end
        drive_cycle(1'b0, 1'b0, 32'd0, 1'b1, 10'h3A);
        checks++; if (g !== 1'b1 || a !== 32'h3A) begin errors++; $display("[TB] FAIL halt_ldr: got grant %0b addr %0h expected 1 3a", g, a); end
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_stay: got halted %0b valid %0b expected 1 0", halted, instr_valid); end
        drive_cycle(1'b0, 1'b1, 32'd5, 1'b0, 10'd0);
        checks++; if (halted !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_leave: got halted %0b valid %0b expected 0 0", halted, instr_valid); end
        drive_cycle(1'b0, 1'b0, 32'd0, 1'b0, 10'd0);
        checks++; if (instr_pc !== 32'd5 || instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL halt_restart: got pc %0d valid %0b expected 5 1", instr_pc, instr_valid); end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b0, 1'b0, 32'd0, 1'b1, 10'h11);
        drive_cycle(1'b0, 1'b0, 32'd0, 1'b1, 10'h12);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (instr !== 32'd0 || instr_pc !== 32'd0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("[TB] FAIL midburst_regs: got %0h %0h %0b %0b expected 0 0 0 0", instr, instr_pc, instr_valid, halted); end
        checks++; if (ldr_grant !== 1'b0) begin errors++; $display("[TB] FAIL midburst_grant: got %0b expected 0", ldr_grant); end
        @(posedge clk);
        #1;
        reset = 1'b0; ldr_req = 1'b0;
        model_reset();
        drive_cycle(1'b0, 1'b0, 32'd0, 1'b0, 10'd0);
        checks++; if (instr_pc !== 32'(RST_PC) || instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL midburst_first: got pc %0h valid %0b expected %0h 1", instr_pc, instr_valid, RST_PC); end
        drive_cycle(1'b0, 1'b0, 32'd0, 1'b0, 10'd0);
        drive_cycle(1'b1, 1'b0, 32'd0, 1'b0, 10'd0);
        drive_cycle(1'b1, 1'b0, 32'd0, 1'b0, 10'd0);
        #2;
        reset = 1'b1;
        #2;
        checks++; if (instr_pc !== 32'd0 || instr_valid !== 1'b0 || mem_addr !== 32'(RST_PC)) begin
            errors++; $display("[TB] FAIL midstall_regs: got pc %0h valid %0b addr %0h expected 0 0 %0h", instr_pc, instr_valid, mem_addr, RST_PC); end
        reset = 1'b0;
        model_reset();
        drive_cycle(1'b0, 1'b0, 32'd0, 1'b0, 10'd0);
        checks++; if (instr_pc !== 32'(RST_PC) || instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL midstall_first: got pc %0h valid %0b expected %0h 1", instr_pc, instr_valid, RST_PC); end
    endtask

    task automatic test_random();
        logic        s;
        logic        r;
        logic [31:0] rpc;
        logic        lr;
        salt = $urandom;
        for (int k = 0; k < 400; k++) begin
            s   = ($urandom_range(3) == 0);
            r   = ($urandom_range(9) == 0);
            rpc = ($urandom_range(7) == 0) ? 32'(1018 + $urandom_range(9)) : 32'($urandom_range(DEPTH - 1));
            lr  = ($urandom_range(4) < 2);
            drive_cycle(s, r, rpc, lr, 10'($urandom));
            checks++; if (g !== eg) begin errors++; $display("[TB] FAIL rand_grant: got %0b expected %0b at %0d", g, eg, k); end
            checks++; if (a !== ea) begin errors++; $display("[TB] FAIL rand_addr: got %0h expected %0h at %0d", a, ea, k); end
            checks++; if (instr !== m_instr) begin errors++; $display("[TB] FAIL rand_instr: got %0h expected %0h at %0d", instr, m_instr, k); end
            checks++; if (instr_pc !== m_ipc) begin errors++; $display("[TB] FAIL rand_instr_pc: got %0h expected %0h at %0d", instr_pc, m_ipc, k); end
            checks++; if (instr_valid !== m_valid) begin errors++; $display("[TB] FAIL rand_valid: got %0b expected %0b at %0d", instr_valid, m_valid, k); end
            checks++; if (halted !== m_halted) begin errors++; $display("[TB] FAIL rand_halted: got %0b expected %0b at %0d", halted, m_halted, k); end
        end
        stall = 1'b0; redirect = 1'b0; ldr_req = 1'b0;
    endtask

`ifdef IF_FETCH_PERF_EN
    task automatic test_perf();
        int exp_fetch;
        int exp_bubble;
        exp_fetch = 0;
        exp_bubble = 0;
        reset = 1'b1;
        #3;
        checks++; if (perf_fetch !== 32'd0 || perf_bubble !== 32'd0) begin errors++; $display("[TB] FAIL perf_reset: got %0d %0d expected 0 0", perf_fetch, perf_bubble); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 100; k++) begin
            if (m_valid) exp_fetch++; else exp_bubble++;
            drive_cycle(1'b0, (k == 20 || k == 50 || k == 80), 32'd10, 1'b0, 10'd0);
        end
        checks++; if (perf_fetch + perf_bubble !== 32'd100) begin errors++; $display("[TB] FAIL perf_sum: got %0d expected 100", perf_fetch + perf_bubble); end
        checks++; if (perf_bubble !== 32'd4) begin errors++; $display("[TB] FAIL perf_bubble: got %0d expected 4", perf_bubble); end
        checks++; if (perf_fetch !== 32'(exp_fetch)) begin errors++; $display("[TB] FAIL perf_fetch: got %0d expected %0d", perf_fetch, exp_fetch); end
        checks++; if (exp_bubble != 4) begin errors++; $display("[TB] FAIL perf_model_bubble: got %0d expected 4", exp_bubble); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        test_reset();
        test_free_run();
        test_redirect_stall();
        test_ldr_burst();
        test_halt();
        test_reset_mid();
        test_random();
`ifdef IF_FETCH_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_controller.md
IF_FETCH_CONTROLLER -- requirements
Module: if_fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 0: word index fetched first after reset.
REQ-002 SHALL have parameter MEM_DEPTH, default 1024: number of instruction-memory words; valid indices are 0..MEM_DEPTH-1.
REQ-003 SHALL have parameter LDR_MAX_BURST, default 4: maximum consecutive loader-granted cycles.
REQ-004 Port list (name, direction, width, meaning); clock and reset come first:
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high reset.
- stall, in, 1: hold the fetch state.
- redirect, in, 1: branch/jump taken.
- redirect_pc, in, 32: new word index.
- mem_addr, out, 32: combinational read address to the instruction memory.
- mem_data, in, 32: combinational read data from the instruction memory.
- instr, out, 32: registered instruction.
- instr_pc, out, 32: word index of instr.
- instr_valid, out, 1: instr is a real fetch.
- ldr_req, in, 1: loader/debug read request.
- ldr_addr, in, 10: loader word index.
- ldr_grant, out, 1: combinational; loader owns the memory this cycle.
- ldr_data, out, 32: mem_data, valid while ldr_grant=1.
- halted, out, 1: PC is out of range; fetch is stopped.

Function
REQ-005 FSM states SHALL be FETCH, LDR and HALT.
REQ-006 In FETCH with no stall, no redirect, no grant and pc<MEM_DEPTH: mem_addr=pc; at the edge, instr<=mem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1. Latency is 1 cycle, throughput 1 instruction per cycle.
REQ-007 Redirect SHALL take priority over stall and grant.
- At the edge: pc<=redirect_pc, instr_valid<=0 (flush).
- The state becomes FETCH, including when leaving HALT or LDR.
REQ-008 Stall=1 without redirect SHALL hold pc, instr, instr_pc and instr_valid unchanged.
REQ-009 Loader grant SHALL be issued when ldr_req=1, no redirect, and either stall=1 or the burst count is below LDR_MAX_BURST.
- mem_addr=ldr_addr (zero-extended) while granted.
REQ-010 While granted and not stalled: pc is held and instr_valid<=0 (bubble).
REQ-011 Burst counter behaviour:
- Increments on each granted cycle.
- After LDR_MAX_BURST consecutive grants, the next cycle SHALL be a forced fetch cycle with ldr_grant=0.
- The counter clears on any non-granted cycle.
REQ-012 If pc>=MEM_DEPTH when a fetch would issue, the FSM SHALL enter HALT. In HALT:
- halted=1, instr_valid<=0, pc held.
- Loader grants are still served.
REQ-013 HALT SHALL be left only by reset or redirect. A redirect to an out-of-range pc re-enters HALT on the following fetch attempt.
REQ-014 pc arithmetic SHALL be 32-bit unsigned; wrap from 0xFFFFFFFF is unreachable because HALT is entered first.

Reset
REQ-015 Asynchronous reset SHALL force: state=FETCH, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, burst counter=0.
REQ-016 ldr_grant SHALL be 0 while reset=1.
REQ-017 Reset asserted mid-burst or mid-stall SHALL discard all state; the first fetch after deassertion SHALL use RESET_PC.

Configuration
REQ-018 Macro IF_FETCH_PERF_EN SHALL gate performance counters.
- When defined: outputs perf_fetch (32) counts instr_valid=1 cycles and perf_bubble (32) counts cycles with instr_valid=0 outside reset.
- Both counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined: both ports and all counter logic are absent.

Structure
REQ-019 A shared package SHALL hold the FSM state enum, the 32-bit word typedef and the MEM_DEPTH/RESET_PC default constants.
REQ-020 Grant and burst logic SHALL be one sub-module, if_fetch_ldr_arb; the FSM and pc datapath stay in the top level.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Reset, then free-run with memory word k = k: instr_pc 0,1,2,... with instr=instr_pc; instr_valid=1 from the 2nd cycle.
- redirect with redirect_pc=0x20 and stall=1 in the same cycle: next cycle instr_valid=0; the following cycle instr_pc=0x20.
- ldr_req held 10 cycles, no stall, LDR_MAX_BURST=4: grant pattern 1111 0 1111 0; exactly 2 valid fetches occur in that window.
- redirect_pc=1022, free-run: fetches 1022 and 1023, then halted=1 and instr_valid=0; redirect to 5 restarts fetch at 5.
- Reset pulsed mid-burst and mid-stall: all outputs return to reset values asynchronously; the first fetch after release is RESET_PC.
- With IF_FETCH_PERF_EN defined, 100 cycles with 3 redirects: perf_fetch + perf_bubble = 100, perf_bubble = 4 (1 start-up + 3 flushes).
